// File: rtl/video_timing_pkg.sv
// Shared mode bundles and axis-bound arithmetic for the raster timing generator.
package video_timing_pkg;

   typedef struct packed {
      int unsigned h_visible;
      int unsigned h_front;
      int unsigned h_sync;
      int unsigned h_back;
      int unsigned v_visible;
      int unsigned v_front;
      int unsigned v_sync;
      int unsigned v_back;
      logic        hsync_pol;
      logic        vsync_pol;
   } timing_mode_t;

   typedef struct packed {
      int unsigned total;
      int unsigned sync_begin;
      int unsigned sync_end;
   } axis_bounds_t;

   localparam timing_mode_t SVGA_800x600_60 = '{
      h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
      v_visible: 600, v_front: 1,  v_sync: 4,   v_back: 23,
      hsync_pol: 1'b1, vsync_pol: 1'b1};

   localparam timing_mode_t VGA_640x480_60 = '{
      h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
      v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33,
      hsync_pol: 1'b0, vsync_pol: 1'b0};

   localparam timing_mode_t XGA_1024x768_60 = '{
      h_visible: 1024, h_front: 24, h_sync: 136, h_back: 160,
      v_visible: 768,  v_front: 3,  v_sync: 6,   v_back: 29,
      hsync_pol: 1'b0, vsync_pol: 1'b0};

   // sync_end is exclusive.
   function automatic axis_bounds_t calc_bounds(input int unsigned visible,
                                                input int unsigned front,
                                                input int unsigned sync,
                                                input int unsigned back);
      axis_bounds_t b;
      b.total      = visible + front + sync + back;
      b.sync_begin = visible + front;
      b.sync_end   = visible + front + sync;
      return b;
   endfunction

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// Enable-gated shift register delaying the sync pair; DEPTH=0 passes straight through.
module sync_delay_line #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] rst_val_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, nrst, en_i, rst_val_i};
      assign dout_o = din_i;
   end else begin : g_shift
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic [WIDTH-1:0] stage_q;
         logic [WIDTH-1:0] stage_d;

         if (gi == 0) begin : g_head
            assign stage_d = din_i;
         end else begin : g_tail
            assign stage_d = g_stage[gi-1].stage_q;
         end

         always_ff @(posedge clk) begin
            if (!nrst) begin
               stage_q <= rst_val_i;
            end else if (en_i) begin
               stage_q <= stage_d;
            end
         end
      end
      assign dout_o = g_stage[DEPTH-1].stage_q;
   end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, decoded flags and delayed syncs,
// all advancing only on pixel-enable cycles.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int          CW         = 16,
   parameter int unsigned H_VISIBLE  = 800,
   parameter int unsigned H_FRONT    = 40,
   parameter int unsigned H_SYNC     = 128,
   parameter int unsigned H_BACK     = 88,
   parameter int unsigned V_VISIBLE  = 600,
   parameter int unsigned V_FRONT    = 1,
   parameter int unsigned V_SYNC     = 4,
   parameter int unsigned V_BACK     = 23,
   parameter bit          HSYNC_POL  = 1'b1,
   parameter bit          VSYNC_POL  = 1'b1,
   parameter int unsigned SYNC_DELAY = 1
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic          en,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          vis,
   output logic          hsync,
   output logic          vsync,
   output logic          line_start,
   output logic          frame_start
);

   localparam axis_bounds_t HB = calc_bounds(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam axis_bounds_t VB = calc_bounds(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_width
      $fatal(1, "video_timing_gen: porch and sync widths must be at least 1");
   end
   if (64'(HB.total) > (64'd1 << CW) || 64'(VB.total) > (64'd1 << CW)) begin : g_bad_total
      $fatal(1, "video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
   end
   if (SYNC_DELAY > 15) begin : g_bad_delay
      $fatal(1, "video_timing_gen: SYNC_DELAY must be 0..15");
   end

   // Bounds are kept one bit wider so an end equal to 2^CW still compares correctly.
   localparam logic [CW-1:0] H_LAST  = CW'(HB.total - 1);
   localparam logic [CW-1:0] V_LAST  = CW'(VB.total - 1);
   localparam logic [CW:0]   H_VIS_W = (CW+1)'(H_VISIBLE);
   localparam logic [CW:0]   V_VIS_W = (CW+1)'(V_VISIBLE);
   localparam logic [CW:0]   HS_B    = (CW+1)'(HB.sync_begin);
   localparam logic [CW:0]   HS_E    = (CW+1)'(HB.sync_end);
   localparam logic [CW:0]   VS_B    = (CW+1)'(VB.sync_begin);
   localparam logic [CW:0]   VS_E    = (CW+1)'(VB.sync_end);
   localparam logic [1:0]    SYNC_IDLE = {~VSYNC_POL, ~HSYNC_POL};

   logic [CW-1:0] hcount_q, hcount_d;
   logic [CW-1:0] vcount_q, vcount_d;
   logic          vis_q, vis_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic [1:0]    sync_raw_q, sync_raw_d;
   logic [1:0]    sync_dly;
   logic          h_wrap, v_wrap;
   logic          raw_h_act, raw_v_act;
   logic [CW:0]   hcount_d_w, vcount_d_w;

   always_comb begin
      h_wrap   = (hcount_q == H_LAST);
      v_wrap   = (vcount_q == V_LAST);
      hcount_d = h_wrap ? '0 : hcount_q + CW'(1);
      vcount_d = vcount_q;
      if (h_wrap) begin
         vcount_d = v_wrap ? '0 : vcount_q + CW'(1);
      end

      // Flags decode the next counter values so they land in the same cycle as the counters.
      hcount_d_w    = {1'b0, hcount_d};
      vcount_d_w    = {1'b0, vcount_d};
      vis_d         = (hcount_d_w < H_VIS_W) && (vcount_d_w < V_VIS_W);
      line_start_d  = (hcount_d == '0);
      frame_start_d = (hcount_d == '0) && (vcount_d == '0);
      raw_h_act     = (hcount_d_w >= HS_B) && (hcount_d_w < HS_E);
      raw_v_act     = (vcount_d_w >= VS_B) && (vcount_d_w < VS_E);
      sync_raw_d    = {raw_v_act ? VSYNC_POL : ~VSYNC_POL,
                       raw_h_act ? HSYNC_POL : ~HSYNC_POL};
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         vis_q         <= 1'b1;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
         sync_raw_q    <= SYNC_IDLE;
      end else if (en) begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         vis_q         <= vis_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         sync_raw_q    <= sync_raw_d;
      end
   end

   sync_delay_line #(
      .WIDTH (2),
      .DEPTH (int'(SYNC_DELAY))
   ) u_sync_delay (
      .clk       (clk),
      .nrst      (nrst),
      .en_i      (en),
      .rst_val_i (SYNC_IDLE),
      .din_i     (sync_raw_q),
      .dout_o    (sync_dly)
   );

   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign vis         = vis_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign hsync       = sync_dly[0];
   assign vsync       = sync_dly[1];

endmodule
